frame_parser: RTL and testbench
===============================

Name: frame_parser

Overview:
- Sits directly downstream of the Manchester receiver top. Consumes its byte stream (one-cycle byte strobe plus an 8-bit byte) in the receiver's output clock domain.
- Hunts for a 2-byte sync word, then reads a length byte and the payload, then checks a CRC-8 trailer.
- Buffers the payload and replays each accepted frame on a valid/ready byte stream with a last-byte marker.
- Flags malformed, corrupt, timed-out and dropped frames.

Parameters:
- MAX_LEN, 64: maximum payload length in bytes, 1..255. Sets buffer depth.
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.
- TIMEOUT, 1024: maximum aclk cycles allowed between consecutive bytes inside a frame, >= 2.

Ports:
- aclk  in  1  single clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle strobe: in_data is a new byte.
- in_data  in  8  received byte.
- m_tdata  out  8  payload byte.
- m_tvalid  out  1  m_tdata is valid.
- m_tlast  out  1  marks the last payload byte of a frame.
- m_tready  in  1  downstream accepts the byte.
- frame_ok  out  1  one-cycle pulse: frame accepted and queued for replay.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  cause of the abort; valid when frame_err=1. 0=bad length, 1=CRC mismatch, 2=timeout, 3=busy drop.
- busy  out  1  high while in SEND.

Behaviour:
- Reset (async assert, sync release): state IDLE; m_tvalid, m_tlast, frame_ok, frame_err, busy = 0; m_tdata = 0; err_code = 0; counters cleared.
- Reset mid-frame or mid-replay discards the frame; no partial replay continues after release.
- FSM: IDLE, SYNC, LEN, PAYLOAD, CRC, SEND.
- IDLE: byte == SYNC0 -> SYNC. Any other byte is ignored.
- SYNC: byte == SYNC1 -> LEN. byte == SYNC0 -> stay in SYNC. Any other byte -> IDLE, no error.
- LEN: byte of 0 or > MAX_LEN -> IDLE with frame_err, err_code=0. Otherwise latch len, start CRC with crc = CRC8(0x00, len byte), -> PAYLOAD.
- PAYLOAD: write the byte to buffer[wr_idx], wr_idx++, update crc. After byte number len -> CRC.
- CRC: byte == crc -> SEND with frame_ok. Otherwise -> IDLE with frame_err, err_code=1.
- CRC-8 definition: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR. Covers the length byte and all payload bytes.
- Timeout: in SYNC/LEN/PAYLOAD/CRC, a gap counter resets on each in_valid. When it reaches TIMEOUT -> IDLE with frame_err, err_code=2.
- A byte arriving in the same cycle the timeout fires counts as in time.
- SEND replay:
  - Buffer is read from index 0; m_tvalid rises 1 cycle after frame_ok.
  - m_tdata/m_tvalid/m_tlast are registered and held stable until the m_tvalid && m_tready handshake.
  - Throughput is 1 byte/cycle when m_tready is held high.
  - m_tlast=1 only on byte len-1.
  - Handshake on the last byte -> IDLE; busy falls in the same cycle m_tvalid falls.
- While in SEND, every in_valid byte is dropped and frame_err pulses with err_code=3, at most once per SEND episode (first dropped byte only).
- frame_ok and frame_err are never high in the same cycle. Every abort goes to IDLE (no resync on the aborting byte).
- in_valid deasserted: no state change other than the gap counter.

Optional Feature:
- FRAME_CRC_EN.
- Defined: CRC state and trailer byte exist as above.
- Undefined:
  - No trailer byte; the frame is SYNC0, SYNC1, len, payload.
  - After the last payload byte -> SEND with frame_ok in that byte's cycle +1.
  - The CRC state does not exist; err_code=1 is never produced.
  - All other behaviour is unchanged.

Test Plan:
- FRAME_CRC_EN defined; bytes A5 5A 02 01 02 CD with m_tready=1 -> frame_ok once; m_tdata 01 then 02 on consecutive cycles; m_tlast only on 02; no frame_err.
- Same frame with trailer 0xCC -> frame_err, err_code=1; m_tvalid never rises.
- Bytes A5 5A 00, then separately A5 5A 41 with MAX_LEN=64 -> frame_err, err_code=0 for each; IDLE afterwards.
- A5 5A 02 01 followed by silence for TIMEOUT cycles -> frame_err, err_code=2 in the TIMEOUT-th gap cycle.
- Valid 3-byte frame with m_tready toggling 1,0,0,1,... -> each byte held stable until handshake; exactly 3 handshakes; the next frame sent during SEND -> a single frame_err with err_code=3.
- Leading noise 00 A5 A5 5A 01 07 + CRC -> A5 A5 resyncs; 07 is delivered with m_tlast=1.

Source files
------------

// File: rtl/frame_parser.sv
// frame_parser: hunts a 2-byte sync word, captures length + payload, and replays accepted frames on a
// valid/ready byte stream. Optional CRC-8 trailer check is enabled by defining FRAME_CRC_EN.
module frame_parser #(
    parameter int unsigned MAX_LEN = 64,
    parameter logic [7:0]  SYNC0   = 8'hA5,
    parameter logic [7:0]  SYNC1   = 8'h5A,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    input  logic       m_tready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned GAP_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

`ifdef FRAME_CRC_EN
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_PAYLOAD, S_CRC, S_SEND} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_PAYLOAD, S_SEND} state_e;
`endif
    typedef enum logic [1:0] {ERR_LEN = 2'd0, ERR_CRC = 2'd1, ERR_TIMEOUT = 2'd2, ERR_BUSY = 2'd3} err_e;

    state_e           state_q;
    err_e             err_code_q;
    logic [7:0]       len_q;
    logic [IDX_W-1:0] idx_q;
    logic [GAP_W-1:0] gap_q;
    logic             drop_seen_q;
    logic [7:0]       m_tdata_q;
    logic             m_tvalid_q, m_tlast_q, frame_ok_q, frame_err_q, busy_q;
    logic [7:0]       buf_mem [MAX_LEN];

    logic in_frame, timeout_hit, wr_en, idx_is_last;

    assign in_frame    = (state_q != S_IDLE) && (state_q != S_SEND);
    // A byte in the cycle the counter would reach TIMEOUT still counts as in time.
    assign timeout_hit = !in_valid && (gap_q == GAP_W'(TIMEOUT - 1));
    assign wr_en       = in_valid && (state_q == S_PAYLOAD);
    assign idx_is_last = (8'(idx_q) == len_q - 8'd1);

`ifdef FRAME_CRC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign crc_d = crc8_step((state_q == S_LEN) ? 8'h00 : crc_q, in_data);
`endif

    // NOTE: payload storage carries no reset; it is always written before it is read back.
    always_ff @(posedge aclk) begin
        if (wr_en) buf_mem[idx_q] <= in_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            err_code_q  <= ERR_LEN;
            len_q       <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            drop_seen_q <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FRAME_CRC_EN
            crc_q       <= '0;
`endif
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            gap_q       <= in_valid ? '0 : gap_q + 1'b1;

            if (in_frame && timeout_hit) begin
                state_q     <= S_IDLE;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
            end else begin
                case (state_q)
                    S_IDLE: if (in_valid && in_data == SYNC0) state_q <= S_SYNC;
                    S_SYNC: if (in_valid) begin
                        if (in_data == SYNC1)      state_q <= S_LEN;
                        else if (in_data != SYNC0) state_q <= S_IDLE;
                    end
                    S_LEN: if (in_valid) begin
                        if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                            state_q     <= S_IDLE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                        end else begin
                            len_q   <= in_data;
                            idx_q   <= '0;
                            state_q <= S_PAYLOAD;
`ifdef FRAME_CRC_EN
                            crc_q   <= crc_d;
`endif
                        end
                    end
                    S_PAYLOAD: if (in_valid) begin
`ifdef FRAME_CRC_EN
                        crc_q <= crc_d;
`endif
                        if (idx_is_last) begin
                            idx_q <= '0;
`ifdef FRAME_CRC_EN
                            state_q <= S_CRC;
`else
                            state_q     <= S_SEND;
                            frame_ok_q  <= 1'b1;
                            busy_q      <= 1'b1;
                            drop_seen_q <= 1'b0;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
`ifdef FRAME_CRC_EN
                    S_CRC: if (in_valid) begin
                        if (in_data == crc_q) begin
                            state_q     <= S_SEND;
                            frame_ok_q  <= 1'b1;
                            busy_q      <= 1'b1;
                            drop_seen_q <= 1'b0;
                        end else begin
                            state_q     <= S_IDLE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CRC;
                        end
                    end
`endif
                    S_SEND: begin
                        if (in_valid && !drop_seen_q) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_BUSY;
                            drop_seen_q <= 1'b1;
                        end
                        // The output register reloads on the same edge it hands off, giving 1 byte/cycle.
                        if (!m_tvalid_q || m_tready) begin
                            if (m_tvalid_q && m_tlast_q) begin
                                m_tvalid_q <= 1'b0;
                                m_tlast_q  <= 1'b0;
                                busy_q     <= 1'b0;
                                state_q    <= S_IDLE;
                            end else begin
                                m_tdata_q  <= buf_mem[idx_q];
                                m_tvalid_q <= 1'b1;
                                m_tlast_q  <= idx_is_last;
                                idx_q      <= idx_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_frame_parser.sv
// Scoreboard bench for frame_parser: generated frames carry their own expected outcome, a monitor
// checks every output pulse and handshake. Works with and without FRAME_CRC_EN.
module tb_frame_parser;
    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 20;
    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;
    localparam int EV_OK = 4;

    typedef struct packed { logic [7:0] data; logic last; } beat_t;
    typedef logic [7:0] bytes8_t [8];

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast;
    logic       m_tready = 1'b0;
    logic       frame_ok, frame_err;
    logic [1:0] err_code;
    logic       busy;

    frame_parser #(.MAX_LEN(MAX_LEN), .SYNC0(SYNC0), .SYNC1(SYNC1), .TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .areset(areset), .in_valid(in_valid), .in_data(in_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    beat_t      exp_beats[$];
    int         exp_evts[$];
    logic [7:0] stim[$];
    int         rdy_mode = 3;  // 0 random, 1 held low, 2 pattern 1,0,0, 3 held high

    task automatic check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        check(name, act == exp, act, exp);
    endtask

    task automatic ev_check(input int got);
        if (exp_evts.size() == 0) check("unexpected_event", 1'b0, got, -1);
        else check_eq("event", got, exp_evts.pop_front());
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    int unsigned ok_cyc = 0;

    always @(negedge aclk) begin
        if (areset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_last  = 1'b0;
        end else begin
            check_eq("ok_err_exclusive", int'(frame_ok & frame_err), 0);
            if (frame_ok) begin
                ev_check(EV_OK);
                ok_cyc = cyc;
                check_eq("busy_at_ok", busy, 1);
            end
            if (frame_err) ev_check(int'(err_code));
            if (prev_valid && !prev_ready) begin
                check_eq("hold_valid", m_tvalid, 1);
                check_eq("hold_data", m_tdata, prev_data);
                check_eq("hold_last", m_tlast, prev_last);
            end
            if (prev_valid && prev_ready) begin
                if (prev_last) begin
                    check_eq("valid_fall", m_tvalid, 0);
                    check_eq("busy_fall", busy, 0);
                end else begin
                    check_eq("back_to_back", m_tvalid, 1);
                end
            end
            if (m_tvalid && !prev_valid) check_eq("valid_latency", int'(cyc - ok_cyc), 1);
            if (m_tvalid) check_eq("busy_while_valid", busy, 1);
            if (m_tvalid && m_tready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 1'b0, m_tdata, -1);
                end else begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    check_eq("beat_data", m_tdata, e.data);
                    check_eq("beat_last", m_tlast, e.last);
                end
            end
            prev_valid = m_tvalid;
            prev_ready = m_tready;
            prev_last  = m_tlast;
            prev_data  = m_tdata;
        end
    end

    initial begin
        int phase = 0;
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0:       m_tready = ($urandom_range(0, 3) != 0);
                1:       m_tready = 1'b0;
                2:       m_tready = (phase % 3 == 0);
                default: m_tready = 1'b1;
            endcase
            phase++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] crc8_of(input int from);
        logic [7:0] crc = 8'h00;
        for (int i = from; i < stim.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                logic fb;
                fb  = crc[7] ^ stim[i][b];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc;
    endfunction

    task automatic load_stim(input bytes8_t b, input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(b[i]);
    endtask

    task automatic add_crc(input int from);
`ifdef FRAME_CRC_EN
        logic [7:0] c;
        c = crc8_of(from);
        stim.push_back(c);
`endif
    endtask

    task automatic build_frame(input int len);
        stim.delete();
        stim.push_back(SYNC0);
        stim.push_back(SYNC1);
        stim.push_back(8'(len));
        for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
        add_crc(2);
    endtask

    task automatic expect_good(input int len_pos);
        int len;
        len = int'(stim[len_pos]);
        for (int i = 0; i < len; i++) exp_beats.push_back({stim[len_pos + 1 + i], 1'(i == len - 1)});
        exp_evts.push_back(EV_OK);
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        repeat (idle) begin @(posedge aclk); #1; end
    endtask

    task automatic send_stim(input bit long_gap, input int tail_idle);
        int pos;
        pos = long_gap ? int'($urandom_range(0, stim.size() - 2)) : -1;
        for (int i = 0; i < stim.size(); i++)
            send_byte(stim[i], (i == stim.size() - 1) ? tail_idle :
                               (i == pos) ? TIMEOUT - 1 : int'($urandom_range(0, 2)));
    endtask

    task automatic wait_events();
        int n = 0;
        while (exp_evts.size() != 0 && n < 200) begin @(posedge aclk); #1; n++; end
        check("event_arrival", n < 200, n, 200);
        if (n >= 200) exp_evts.delete();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_beats.size() != 0 || exp_evts.size() != 0) && n < 3000) begin
            @(posedge aclk); #1; n++;
        end
        check("drain", n < 3000, n, 3000);
        if (n >= 3000) begin exp_beats.delete(); exp_evts.delete(); end
        repeat (2) begin @(posedge aclk); #1; end
    endtask

    // Sends stim, leaving the final byte followed by silence; frame_err(timeout) must appear
    // TIMEOUT..TIMEOUT+1 gap cycles after that final byte.
    task automatic run_timeout();
        int at = 0;
        exp_evts.push_back(2);
        for (int i = 0; i < stim.size() - 1; i++) send_byte(stim[i], int'($urandom_range(0, 2)));
        in_valid = 1'b1;
        in_data  = stim[stim.size() - 1];
        @(posedge aclk); #1;
        in_valid = 1'b0;
        for (int j = 1; j <= TIMEOUT + 3; j++) begin
            @(negedge aclk);
            if (frame_err && at == 0) at = j;
            @(posedge aclk); #1;
        end
        check("timeout_latency", at == TIMEOUT || at == TIMEOUT + 1, at, TIMEOUT + 1);
        wait_drain();
    endtask

    task automatic run_noise();
        int n;
        logic [7:0] b;
        stim.delete();
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (b == SYNC0);
            stim.push_back(b);
        end
        if ($urandom_range(0, 1) == 1) begin
            stim.push_back(SYNC0);
            do b = 8'($urandom); while (b == SYNC0 || b == SYNC1);
            stim.push_back(b);
        end
        send_stim(1'b0, 1);
    endtask

    function automatic int rand_len();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAX_LEN)) : int'($urandom_range(1, 8));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_m_tlast", m_tlast, 0);
        check_eq("rst_m_tdata", m_tdata, 0);
        check_eq("rst_frame_ok", frame_ok, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_busy", busy, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end

        // Reference frame: bytes 01 02 back to back with m_tready high.
        rdy_mode = 3;
`ifdef FRAME_CRC_EN
        load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'hCD, 8'h00, 8'h00}, 6);
`else
        load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00}, 5);
`endif
        expect_good(2);
        send_stim(1'b0, 2);
        wait_drain();

`ifdef FRAME_CRC_EN
        load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'hCC, 8'h00, 8'h00}, 6);
        exp_evts.push_back(1);
        send_stim(1'b0, 2);
        wait_drain();
`endif

        // Length boundaries: 0 and MAX_LEN+1 rejected, 1 and MAX_LEN accepted.
        load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        exp_evts.push_back(0);
        send_stim(1'b0, 2);
        wait_drain();
        load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        exp_evts.push_back(0);
        send_stim(1'b0, 2);
        wait_drain();
        build_frame(1);
        expect_good(2);
        send_stim(1'b0, 2);
        wait_drain();
        build_frame(MAX_LEN);
        expect_good(2);
        send_stim(1'b0, 2);
        wait_drain();

        // Leading noise with repeated SYNC0 resyncs.
        load_stim(bytes8_t'{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h07, 8'h00, 8'h00}, 6);
        add_crc(4);
        expect_good(4);
        send_stim(1'b0, 2);
        wait_drain();

        // Timeouts in PAYLOAD and in SYNC, then an in-time gap of TIMEOUT-1 idle cycles.
        load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        run_timeout();
        load_stim(bytes8_t'{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
        run_timeout();
        build_frame(4);
        expect_good(2);
        send_stim(1'b1, 2);
        wait_drain();

        // A frame arriving during replay is dropped with a single busy error.
        rdy_mode = 1;
        build_frame(3);
        expect_good(2);
        send_stim(1'b0, 2);
        wait_events();
        exp_evts.push_back(3);
        build_frame(4);
        send_stim(1'b0, 1);
        wait_events();
        rdy_mode = 2;
        wait_drain();

        // Reset mid-frame: the abandoned frame must not time out or replay.
        rdy_mode = 3;
        load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        send_stim(1'b0, 0);
        areset = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        areset = 1'b0;
        repeat (TIMEOUT + 5) begin @(posedge aclk); #1; end
        build_frame(2);
        expect_good(2);
        send_stim(1'b0, 2);
        wait_drain();

        // Reset mid-replay: outputs clear at once and nothing resumes.
        rdy_mode = 1;
        build_frame(5);
        expect_good(2);
        send_stim(1'b0, 2);
        wait_events();
        repeat (3) begin @(posedge aclk); #1; end
        @(negedge aclk);
        check_eq("presenting_before_reset", m_tvalid, 1);
        @(posedge aclk); #1;
        areset = 1'b1;
        #1;
        check_eq("rst_async_m_tvalid", m_tvalid, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_m_tdata", m_tdata, 0);
        exp_beats.delete();
        repeat (2) begin @(posedge aclk); #1; end
        areset = 1'b0;
        rdy_mode = 3;
        repeat (20) begin @(posedge aclk); #1; end
        @(negedge aclk);
        check_eq("idle_after_reset_busy", busy, 0);
        @(posedge aclk); #1;

        // Randomised mix of frames and faults.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            rdy_mode = ($urandom_range(0, 1) == 1) ? 0 : 3;
            case (kind)
                0, 1, 2, 3: begin
                    build_frame(rand_len());
                    expect_good(2);
                    send_stim($urandom_range(0, 3) == 0, 2);
                    wait_drain();
                end
                4: begin
                    load_stim(bytes8_t'{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
                    if ($urandom_range(0, 1) == 1) stim[2] = 8'($urandom_range(MAX_LEN + 1, 255));
                    exp_evts.push_back(0);
                    send_stim(1'b0, 2);
                    wait_drain();
                end
                5: begin
                    build_frame(rand_len());
`ifdef FRAME_CRC_EN
                    stim[stim.size() - 1] = stim[stim.size() - 1] ^ 8'($urandom_range(1, 255));
                    exp_evts.push_back(1);
`else
                    expect_good(2);
`endif
                    send_stim(1'b0, 2);
                    wait_drain();
                end
                6, 7: begin
                    int keep;
                    build_frame(rand_len());
                    keep = int'($urandom_range(1, stim.size() - 1));
                    while (stim.size() > keep) void'(stim.pop_back());
                    run_timeout();
                end
                default: begin
                    run_noise();
                    wait_drain();
                end
            endcase
        end

        repeat (5) begin @(posedge aclk); #1; end
        check_eq("leftover_beats", exp_beats.size(), 0);
        check_eq("leftover_events", exp_evts.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
